// File: rtl/adc_arb_pkg.sv
// ---------------------------------------------------------------------------
// adc_arb_pkg
// Shared constants for the ADC result arbiter: FSM state encoding, default
// word-type tag, output-word field layout and the accumulator result width.
// Also provides the output-word packing helper used by the arbiter.
// ---------------------------------------------------------------------------
package adc_arb_pkg;

    // FSM state encoding (plain constants so older tooling can share it)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Field widths
    localparam int RESULT_W  = 40;
    localparam int ID_W      = 8;
    localparam int TAG_W     = 4;
    localparam int CH_IDX_W  = 4;
    localparam int PAD_W     = 8;
    localparam int WORD_W    = 64;

    // Field offsets inside the 64-bit output word
    localparam int TAG_LSB    = 60;
    localparam int CH_LSB     = 56;
    localparam int ID_LSB     = 48;
    localparam int PAD_LSB    = 40;
    localparam int RESULT_LSB = 0;

    // Default word-type tag for accumulator results
    localparam logic [TAG_W-1:0] TAG_DEFAULT = 4'h2;

    // Build one output word: tag | channel | counter id | zero pad | result
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [TAG_W-1:0]    tag,
        input logic [CH_IDX_W-1:0] ch,
        input logic [ID_W-1:0]     id,
        input logic [RESULT_W-1:0] res
    );
        return {tag, ch, id, 8'h00, res};
    endfunction

endpackage

// File: rtl/adc_result_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner search. Starting at last+1 and wrapping
// modulo NCH, returns the index of the first set request bit.
//   req   : request vector, one bit per channel
//   last  : index granted most recently (must be < NCH)
//   grant : winning channel index (0 when nothing is requested)
//   found : high when at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
    import adc_arb_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]      req,
    input  logic [CH_IDX_W-1:0] last,
    output logic [CH_IDX_W-1:0] grant,
    output logic                found
);

    // Scan NCH positions starting after the last winner; first hit wins
    always_comb begin
        grant = {CH_IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= int'(NCH); k++) begin
            int  idx;
            logic hit;
            idx   = (int'(last) + k) % int'(NCH);
            hit   = req[idx] & ~found;
            grant = hit ? CH_IDX_W'(idx) : grant;
            found = found | req[idx];
        end
    end

endmodule

// File: rtl/adc_result_arbiter.sv
// ---------------------------------------------------------------------------
// adc_result_arbiter
// Round-robin arbiter that moves per-channel ADC accumulator results into a
// shared 64-bit data FIFO. One word is written per transaction through an
// IDLE -> WRITE -> RELEASE sequence; the granted channel gets a one-cycle
// acknowledge together with the write strobe.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : allows new grants (an in-flight word always completes)
//   ch_result       : NCH x 40-bit results, channel i at [40i+39:40i]
//   ch_counter_id   : NCH x 8-bit counter ids, channel i at [8i+7:8i]
//   ch_ready        : per-channel result-ready levels
//   ch_ack          : per-channel one-cycle acknowledge
//   out_data        : FIFO write data {tag, ch, id, 8'h00, result}
//   out_valid       : one-cycle FIFO write strobe
//   out_full        : FIFO full flag, holds the word in WRITE
//   stall_count     : saturating count of WRITE cycles blocked by out_full
//   stat_clear      : synchronous clear of stall_count (wins over increment)
// ---------------------------------------------------------------------------
module adc_result_arbiter
    import adc_arb_pkg::*;
#(
    parameter int unsigned      NCH = 4,
    parameter logic [TAG_W-1:0] TAG = TAG_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NCH*RESULT_W-1:0] ch_result,
    input  logic [NCH*ID_W-1:0]     ch_counter_id,
    input  logic [NCH-1:0]          ch_ready,
    output logic [NCH-1:0]          ch_ack,
    output logic [WORD_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_full,
    output logic [15:0]             stall_count,
    input  logic                    stat_clear
);

    localparam logic [CH_IDX_W-1:0] LAST_RESET = CH_IDX_W'(NCH - 1);

    logic [1:0]          state_r;
    logic [CH_IDX_W-1:0] last_grant_r;
    logic [NCH-1:0]      mask_r;
    logic [CH_IDX_W-1:0] lat_ch_r;
    logic [ID_W-1:0]     lat_id_r;
    logic [RESULT_W-1:0] lat_result_r;
    logic [WORD_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic [NCH-1:0]      ch_ack_r;
    logic [15:0]         stall_count_r;

    logic [NCH-1:0]      req_s;
    logic [CH_IDX_W-1:0] pick_idx_s;
    logic                pick_found_s;
    logic [RESULT_W-1:0] sel_result_s;
    logic [ID_W-1:0]     sel_id_s;
    logic [NCH-1:0]      lat_onehot_s;

    // The channel just served is hidden for one IDLE cycle so a source that
    // has not yet dropped ready is not granted again immediately.
    assign req_s = ch_ready & ~mask_r;

    rr_pick #(
        .NCH (NCH)
    ) u_rr_pick (
        .req   (req_s),
        .last  (last_grant_r),
        .grant (pick_idx_s),
        .found (pick_found_s)
    );

    // rr_pick only returns indices below NCH, so these selects stay in range
    assign sel_result_s = ch_result[RESULT_W*int'(pick_idx_s) +: RESULT_W];
    assign sel_id_s     = ch_counter_id[ID_W*int'(pick_idx_s) +: ID_W];

    // One-hot decode of the latched winner for ack and mask
    always_comb begin
        lat_onehot_s = {NCH{1'b0}};
        for (int i = 0; i < int'(NCH); i++) begin
            lat_onehot_s[i] = (lat_ch_r == CH_IDX_W'(i));
        end
    end

    // Transaction FSM: grant/latch, write when FIFO has room, one-cycle release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= LAST_RESET;
            mask_r       <= {NCH{1'b0}};
            lat_ch_r     <= {CH_IDX_W{1'b0}};
            lat_id_r     <= {ID_W{1'b0}};
            lat_result_r <= {RESULT_W{1'b0}};
            out_data_r   <= {WORD_W{1'b0}};
            out_valid_r  <= 1'b0;
            ch_ack_r     <= {NCH{1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            ch_ack_r    <= {NCH{1'b0}};
            mask_r      <= {NCH{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (enable && pick_found_s) begin
                        lat_ch_r     <= pick_idx_s;
                        lat_id_r     <= sel_id_s;
                        lat_result_r <= sel_result_s;
                        last_grant_r <= pick_idx_s;
                        state_r      <= ST_WRITE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (!out_full) begin
                        out_valid_r <= 1'b1;
                        ch_ack_r    <= lat_onehot_s;
                        out_data_r  <= pack_word(TAG, lat_ch_r, lat_id_r, lat_result_r);
                        state_r     <= ST_RELEASE;
                    end else begin
                        state_r <= ST_WRITE;
                    end
                end
                ST_RELEASE: begin
                    mask_r  <= lat_onehot_s;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating stall counter; clear takes priority over an increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= 16'h0000;
        end else if (stat_clear) begin
            stall_count_r <= 16'h0000;
        end else if ((state_r == ST_WRITE) && out_full && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'h0001;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign ch_ack      = ch_ack_r;
    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_adc_result_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adc_result_arbiter
// Self-checking bench for adc_result_arbiter (NCH=4). Stimulus pushes the
// expected {word, ack} into a scoreboard queue; a negedge monitor pops and
// compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_adc_result_arbiter;

    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [NCH*40-1:0] ch_result = '0;
    logic [NCH*8-1:0]  ch_counter_id = '0;
    logic [NCH-1:0]    ch_ready = '0;
    logic [NCH-1:0]    ch_ack;
    logic [63:0]       out_data;
    logic              out_valid;
    logic              out_full = 1'b0;
    logic [15:0]       stall_count;
    logic              stat_clear = 1'b0;

    int total_checks  = 0;
    int passed_checks = 0;

    logic [63:0] exp_data_q[$];
    logic [3:0]  exp_ack_q[$];

    logic [39:0] res_tbl[NCH];
    logic [7:0]  id_tbl[NCH];

    adc_result_arbiter #(
        .NCH (NCH),
        .TAG (4'h2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .ch_result     (ch_result),
        .ch_counter_id (ch_counter_id),
        .ch_ready      (ch_ready),
        .ch_ack        (ch_ack),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_full      (out_full),
        .stall_count   (stall_count),
        .stat_clear    (stat_clear)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_data();
        for (int i = 0; i < NCH; i++) begin
            ch_result[i*40 +: 40]   = res_tbl[i];
            ch_counter_id[i*8 +: 8] = id_tbl[i];
        end
    endtask

    // Expected word built from the field layout: tag, channel, id, pad, result
    task automatic push_exp(input int ch);
        logic [3:0] chv;
        chv = 4'(ch);
        exp_data_q.push_back({4'h2, chv, id_tbl[ch], 8'h00, res_tbl[ch]});
        exp_ack_q.push_back(4'b0001 << ch);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected word
    always @(negedge clk) begin
        if (ch_ack !== 4'b0000) begin
            check_val("ack_onehot", 64'($onehot(ch_ack)), 64'd1);
            check_val("ack_with_valid", 64'(out_valid), 64'd1);
        end
        if (out_valid === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                check_val("unexpected_valid", 64'(out_valid), 64'd0);
            end else begin
                logic [63:0] ed;
                logic [3:0]  ea;
                ed = exp_data_q.pop_front();
                ea = exp_ack_q.pop_front();
                check_val("sb_data", out_data, ed);
                check_val("sb_ack", 64'(ch_ack), 64'(ea));
            end
        end
    end

    initial begin
        for (int i = 0; i < NCH; i++) begin
            res_tbl[i] = {8'hA0 + 8'(i), 32'hC0DE_0000 + 32'(i)};
            id_tbl[i]  = 8'h10 + 8'(i);
        end
        apply_data();

        // Reset state
        do_reset();
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_ack", 64'(ch_ack), 64'd0);
        check_val("rst_data", out_data, 64'd0);
        check_val("rst_stall", 64'(stall_count), 64'd0);

        // Single channel, latency, data held after grant
        res_tbl[1] = 40'h00_1234_5678;
        id_tbl[1]  = 8'h07;
        apply_data();
        enable   = 1'b1;
        ch_ready = 4'b0010;
        push_exp(1);
        tick();                         // grant edge
        ch_ready = 4'b0000;
        res_tbl[1] = 40'hFF_FFFF_FFFF;   // must not leak into the latched word
        apply_data();
        check_val("lat_n1_valid", 64'(out_valid), 64'd0);
        tick();
        check_val("lat_n2_valid", 64'(out_valid), 64'd1);
        check_val("single_word", out_data, 64'h2107_0000_1234_5678);
        check_val("single_ack", 64'(ch_ack), 64'h2);
        tick();
        check_val("release_valid", 64'(out_valid), 64'd0);
        check_val("release_ack", 64'(ch_ack), 64'd0);
        tick();
        res_tbl[1] = 40'h00_1234_5678;
        apply_data();

        // Round robin from reset: 0,1,2,3,0
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 5; k++) push_exp(k % NCH);
        ch_ready = 4'hF;
        for (int k = 0; k < 13; k++) tick();
        ch_ready = 4'h0;
        for (int k = 0; k < 4; k++) tick();
        check_val("rr_drained", 64'(exp_data_q.size()), 64'd0);

        // FIFO full for 10 WRITE cycles
        out_full = 1'b1;
        ch_ready = 4'b0100;
        push_exp(2);
        tick();                         // grant edge
        ch_ready = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("stall_no_valid", 64'(out_valid), 64'd0);
        end
        check_val("stall_10", 64'(stall_count), 64'd10);
        out_full = 1'b0;
        tick();
        check_val("stall_write_valid", 64'(out_valid), 64'd1);
        check_val("stall_hold", 64'(stall_count), 64'd10);
        tick();
        tick();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        check_val("stat_clear", 64'(stall_count), 64'd0);

        // Reset while in WRITE: word discarded, next grant is channel 0
        out_full = 1'b1;
        ch_ready = 4'b1000;
        tick();                         // grant ch3, now in WRITE
        ch_ready = 4'b0000;
        rst = 1'b1;
        #2;
        check_val("rstw_valid", 64'(out_valid), 64'd0);
        check_val("rstw_ack", 64'(ch_ack), 64'd0);
        check_val("rstw_data", out_data, 64'd0);
        tick();
        rst = 1'b0;
        out_full = 1'b0;
        tick();
        tick();
        check_val("rstw_quiet", 64'(out_valid), 64'd0);
        ch_ready = 4'hF;
        push_exp(0);
        tick();
        ch_ready = 4'h0;
        tick();
        check_val("rstw_next_ch0", 64'(ch_ack), 64'h1);
        tick();
        tick();

        // enable low blocks grants; dropping it mid-transaction does not abort
        enable   = 1'b0;
        ch_ready = 4'hF;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("en_off_no_valid", 64'(out_valid), 64'd0);
        end
        enable = 1'b1;
        push_exp(1);
        tick();                         // grant ch1
        enable   = 1'b0;
        ch_ready = 4'h0;
        tick();
        check_val("en_drop_completes", 64'(out_valid), 64'd1);
        tick();
        tick();

        // Clear priority over increment, then saturation
        enable   = 1'b1;
        out_full = 1'b1;
        ch_ready = 4'b0100;
        push_exp(2);
        tick();                         // grant
        ch_ready = 4'b0000;
        tick();
        check_val("prio_pre", 64'(stall_count), 64'd1);
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        check_val("clear_priority", 64'(stall_count), 64'd0);
        tick();
        check_val("prio_resume", 64'(stall_count), 64'd1);
        for (int k = 0; k < 70000; k++) @(posedge clk);
        #1;
        check_val("saturate", 64'(stall_count), 64'hFFFF);
        check_val("sat_no_valid", 64'(out_valid), 64'd0);
        out_full = 1'b0;
        tick();
        check_val("sat_write", 64'(out_valid), 64'd1);
        check_val("sat_hold", 64'(stall_count), 64'hFFFF);
        tick();
        tick();

        check_val("sb_drained", 64'(exp_data_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
